// File: rtl/y86_seq_controller.sv
// rtl/y86_seq_controller.sv - multi-cycle stage sequencer for the sequential Y86 core
// Owns the architectural PC, processor status and the cycle/retired counters.
module y86_seq_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             imem_ack,
   input  logic             imem_error,
   input  logic [3:0]       icode,
   input  logic             Cnd,
   input  logic [31:0]      valC,
   input  logic [31:0]      valM,
   input  logic [31:0]      valP,
   input  logic             dmem_ack,
   input  logic             dmem_error,
   output logic [31:0]      pc,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             d_en,
   output logic             e_en,
   output logic             w_en,
   output logic [1:0]       stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_BOOT      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PCUPD     = 3'd6,
      S_STOP      = 3'd7
   } state_t;

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [3:0]       r_ir;
   logic [1:0]       r_stat;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_retired_cnt;

   state_t           w_next_state;
   logic [1:0]       w_next_stat;
   logic             w_ir_load;
   logic             w_uses_mem;
   logic             w_pc_load;
   logic             w_cycle_inc;
   logic [31:0]      w_next_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_stat  = r_stat;
      w_ir_load    = 1'b0;
      case (r_state)
         S_BOOT: w_next_state = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               if (imem_error) begin
                  w_next_stat  = STAT_ADR;
                  w_next_state = S_STOP;
               end else begin
                  w_ir_load = 1'b1;
                  if (icode == 4'h0) begin
                     w_next_stat  = STAT_HLT;
                     w_next_state = S_STOP;
                  end else if (icode > 4'hB) begin
                     w_next_stat  = STAT_INS;
                     w_next_state = S_STOP;
                  end else begin
                     w_next_state = S_DECODE;
                  end
               end
            end
         end
         S_DECODE:  w_next_state = S_EXECUTE;
         S_EXECUTE: w_next_state = w_uses_mem ? S_MEMORY : S_WRITEBACK;
         S_MEMORY: begin
            if (dmem_ack) begin
               if (dmem_error) begin
                  w_next_stat  = STAT_ADR;
                  w_next_state = S_STOP;
               end else begin
                  w_next_state = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: w_next_state = S_PCUPD;
         S_PCUPD:     w_next_state = S_FETCH;
         S_STOP:      w_next_state = S_STOP;
         default:     w_next_state = S_BOOT;
      endcase
   end

   // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
   always_comb begin
      w_uses_mem = 1'b0;
      case (r_ir)
         4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_uses_mem = 1'b1;
         default:                            w_uses_mem = 1'b0;
      endcase
   end

   always_comb begin
      w_next_pc = valP;
      case (r_ir)
         4'h7:    w_next_pc = Cnd ? valC : valP;
         4'h8:    w_next_pc = valC;
         4'h9:    w_next_pc = valM;
         default: w_next_pc = valP;
      endcase
   end

   assign w_pc_load   = (r_state == S_PCUPD);
   assign w_cycle_inc = (r_state != S_BOOT) && (r_state != S_STOP);

   // A faulting or halting instruction never reaches PCUPD, so it is not retired
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_ir          <= 4'h0;
         r_stat        <= STAT_AOK;
         r_cycle_cnt   <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_stat <= w_next_stat;
         if (w_ir_load) begin
            r_ir <= icode;
         end
         if (w_pc_load) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + CNT_ONE;
         end
         if (w_cycle_inc) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
         end
      end
   end

   assign pc          = r_pc;
   assign stat        = r_stat;
   assign cycle_cnt   = r_cycle_cnt;
   assign retired_cnt = r_retired_cnt;
   assign imem_req    = (r_state == S_FETCH);
   assign dmem_req    = (r_state == S_MEMORY);
   assign d_en        = (r_state == S_DECODE);
   assign e_en        = (r_state == S_EXECUTE);
   assign w_en        = (r_state == S_WRITEBACK);

endmodule

// File: doc/y86_seq_controller.md
# y86_seq_controller

Multi-cycle stage sequencer for the sequential Y86 core. It owns the architectural PC register and steps the datapath through fetch, decode, execute, memory, write-back and PC-update, one stage per state. It handshakes with instruction and data memory and skips the memory stage for instructions that do not use it. It applies the Y86 next-PC rules and tracks processor status, cycle count and retired-instruction count.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 32, width of cycle and retired counters
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_ack  in  1  instruction fetch complete; icode/valC/valP valid this cycle
- imem_error  in  1  fetch address invalid, qualified by imem_ack
- icode  in  4  instruction code from fetch, sampled on imem_ack
- Cnd  in  1  condition result from execute, sampled in PCUPD
- valC, valM, valP  in  32 each  constant, memory read value, fall-through PC
- dmem_ack  in  1  data access complete
- dmem_error  in  1  data address invalid, qualified by dmem_ack
- pc  out  32  current architectural PC
- imem_req  out  1  high in FETCH
- dmem_req  out  1  high in MEMORY
- d_en, e_en, w_en  out  1 each  one-cycle stage strobes (high in DECODE/EXECUTE/WRITEBACK)
- stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS
- cycle_cnt, retired_cnt  out  CNT_W each  counters

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- BOOT: one cycle after reset release, all strobes/requests 0; -> FETCH.
- FETCH: imem_req=1; hold until imem_ack. On ack: imem_error=1 -> stat=ADR, STOP; else latch icode into ir (4-bit register). If icode=0 -> stat=HLT, STOP. If icode>4'hB -> stat=INS, STOP. Else -> DECODE.
- DECODE -> EXECUTE -> (ir in {4,5,8,9,A,B} ? MEMORY : WRITEBACK).
- MEMORY: dmem_req=1; hold until dmem_ack. dmem_error=1 -> stat=ADR, STOP; else -> WRITEBACK.
- WRITEBACK -> PCUPD.
- PCUPD: pc <= next_pc; retired_cnt += 1; -> FETCH. next_pc: ir=8 -> valC; ir=7 -> (Cnd ? valC : valP); ir=9 -> valM; otherwise valP.
- STOP: terminal; all requests/strobes 0; pc, stat, counters frozen until reset. Halting/faulting instruction is not retired and pc keeps its address.
- cycle_cnt increments every cycle in any state except BOOT and STOP; counters wrap modulo 2^CNT_W.
- imem_ack/dmem_ack outside FETCH/MEMORY respectively are ignored.

## Timing
- Reset (asynchronous, rst_n=0): state=BOOT, pc=RESET_PC, ir=0, stat=AOK, cycle_cnt=0, retired_cnt=0, all requests/strobes 0. Reset mid-instruction abandons it; no pc update.
- Requests and strobes are decoded from the registered state (no input-to-output combinational path).
- Zero-wait ack (ack in the first request cycle) is legal; minimum FETCH and MEMORY residence is 1 cycle.
- Instruction latency with zero-wait memory: 5 cycles without memory stage, 6 cycles with it; N wait cycles add N.
- First imem_req appears in cycle 2 after reset release (BOOT occupies cycle 1).
- pc changes only on the clock edge leaving PCUPD.

## Test plan
- Reset, icode=1 (nop) repeatedly, valP=pc+1, zero-wait acks -> pc 0,1,2,3 at 5-cycle intervals; retired_cnt=3 after third PCUPD; dmem_req never asserted.
- jXX (icode=7), valC=0x40, valP=0x09: Cnd=1 -> pc=0x40; repeat with Cnd=0 -> pc=0x09; no MEMORY state.
- call (8) valC=0x100 -> pc=0x100 after 6 cycles; ret (9) valM=0x2A with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, pc=0x2A after 9 cycles.
- halt (0) at pc=0x10 -> stat=HLT, STOP, pc stays 0x10, retired_cnt unchanged, cycle_cnt frozen; icode=0xC -> stat=INS.
- imem_error with ack -> stat=ADR, no DECODE; mrmovq (5) with dmem_error on ack -> stat=ADR, w_en never pulses.
- Assert rst_n=0 during MEMORY wait -> immediately pc=RESET_PC, stat=AOK, dmem_req=0, counters 0; sequencing restarts via BOOT.
